fault_led_ctrl: RTL and testbench
=================================

Name: fault_led_ctrl

Overview:
- Parametrised, registered successor to the combinational unit-LED decoder. Drives one red, green and blue (z) LED per unit for NUM_UNITS units.
- Latches per-unit status events (infrastructure fault, path block, block drop) until explicitly cleared, with a fixed priority between event types.
- Optional blink generation on latched LEDs.
- Sits between the bot's event/unit-tracking logic and the LED output pins.

Parameters:
- NUM_UNITS, 3, number of units (LED triplets); 1..16.
- IDX_W, 2, width of unit index ports; must satisfy 2^IDX_W >= NUM_UNITS.
- BLINK_DIV, 25000000, clock cycles per blink half-period (used only with BLINK_EN); >= 2.

Ports:
- clk_50M  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ev_valid  input  1  event strobe; other ev_* inputs are sampled when high
- ev_unit  input  IDX_W  unit index of the event
- i_fault  input  1  infrastructure-fault event flag
- p_block  input  1  path-block event flag
- b_drop  input  1  block-drop event flag
- clr_valid  input  1  clear strobe for one unit
- clr_unit  input  IDX_W  unit index to clear
- clr_all  input  1  clear every unit
- r  output  NUM_UNITS  red LEDs; bit k = unit k
- g  output  NUM_UNITS  green LEDs; bit k = unit k
- z  output  NUM_UNITS  blue LEDs; bit k = unit k
- active_cnt  output  IDX_W+1  number of units not in IDLE

Behaviour:
- Per-unit 2-bit state, encoded IDLE=0, DROP=1, BLOCK=2, FAULT=3. Priority is FAULT > BLOCK > DROP.
- Reset (synchronous, active-high, effective only at a clk_50M edge):
  - all states go to IDLE;
  - r, g, z and active_cnt are 0;
  - the blink counter is 0 and the blink phase is 1.
- Event decode when ev_valid=1: i_fault selects FAULT, else p_block selects BLOCK, else b_drop selects DROP, else no event (ignored).
- Event update: unit ev_unit moves to the decoded state only if that state's encoding >= its current state. A lower-priority event never downgrades a latched higher state.
- ev_unit >= NUM_UNITS: event ignored, no state change.
- Clear:
  - clr_valid=1 sends unit clr_unit to IDLE;
  - clr_unit >= NUM_UNITS is ignored;
  - clr_all=1 sends all units to IDLE.
- Simultaneous clear and event in the same cycle:
  - clear is applied first, then the event, so the event wins on that unit;
  - the same holds for clr_all, which leaves only the event unit set.
- Outputs are registered from the next state: an event at edge N is visible on r/g/z after edge N (1-cycle latency).
- Output mapping per unit k: FAULT gives r[k]=1; BLOCK gives z[k]=1; DROP gives g[k]=1; IDLE gives all 0. At most one of r[k], g[k], z[k] is high.
- active_cnt: registered count of units with state != IDLE, updated on the same edge as r/g/z.
- Reset asserted mid-operation overrides any concurrent event or clear in that cycle.
- Outputs never glitch between cycles, and no combinational path runs from inputs to outputs.

Optional Feature:
- Macro: FAULT_LED_BLINK_EN.
- Defined:
  - a free-running counter runs 0..BLINK_DIV-1; on wrap the phase toggles;
  - FAULT LEDs (r) are ANDed with phase, so r blinks with period 2*BLINK_DIV;
  - BLOCK and DROP LEDs stay steady;
  - the counter and phase are cleared by reset only, not by events.
- Undefined: no counter is instantiated and all LEDs are steady.

Test Plan:
- Reset, then idle 5 cycles -> r=g=z=000, active_cnt=0.
- ev_valid, ev_unit=1, b_drop=1 -> next cycle g=010, active_cnt=1. Then ev_unit=1, i_fault=1 -> r=010, g=000, active_cnt=1.
- Unit 2 in FAULT, then event ev_unit=2, p_block=1 -> state unchanged, r=100, z=000. Then clr_valid, clr_unit=2 -> r=000, active_cnt=0.
- Same cycle: clr_all=1 with ev_valid, ev_unit=0, p_block=1, while units 1 and 2 are latched -> z=001, r=g=000 on units 1 and 2, active_cnt=1. Separately, ev_unit=3 (NUM_UNITS=3) -> no change.
- All three flags high on ev_unit=0 -> r=001 only. Then reset asserted in the same cycle as an event -> all outputs 0.
- FAULT_LED_BLINK_EN with BLINK_DIV=4, unit 0 in FAULT, unit 1 in DROP -> r[0] is high for 4 cycles and low for 4, repeating; g[1] stays steady high.

Source files
------------

// File: rtl/fault_led_ctrl.sv
// Registered per-unit fault/block/drop LED latch with clear strobes and an active-unit count.
// Optional r-LED blinking is compiled in when FAULT_LED_BLINK_EN is defined.
module fault_led_ctrl #(
   parameter int NUM_UNITS = 3,
   parameter int IDX_W     = 2,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                 clk_50M,
   input  logic                 reset,
   input  logic                 ev_valid,
   input  logic [IDX_W-1:0]     ev_unit,
   input  logic                 i_fault,
   input  logic                 p_block,
   input  logic                 b_drop,
   input  logic                 clr_valid,
   input  logic [IDX_W-1:0]     clr_unit,
   input  logic                 clr_all,
   output logic [NUM_UNITS-1:0] r,
   output logic [NUM_UNITS-1:0] g,
   output logic [NUM_UNITS-1:0] z,
   output logic [IDX_W:0]       active_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DROP  = 2'd1,
      ST_BLOCK = 2'd2,
      ST_FAULT = 2'd3
   } unit_state_t;

   unit_state_t ev_state;

   always_comb begin
      ev_state = ST_IDLE;
      if (ev_valid) begin
         if (i_fault)      ev_state = ST_FAULT;
         else if (p_block) ev_state = ST_BLOCK;
         else if (b_drop)  ev_state = ST_DROP;
      end
   end

   logic [NUM_UNITS-1:0] fault_d;
   logic [NUM_UNITS-1:0] block_d;
   logic [NUM_UNITS-1:0] drop_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
         unit_state_t st_q;
         unit_state_t st_d;
         unit_state_t st_clr;
         logic        ev_hit;
         logic        clr_hit;

         // Out-of-range unit indices never match any gi, so they are ignored for free.
         assign ev_hit  = (ev_state != ST_IDLE) && (ev_unit == IDX_W'(gi));
         assign clr_hit = clr_all || (clr_valid && (clr_unit == IDX_W'(gi)));

         always_comb begin
            st_clr = clr_hit ? ST_IDLE : st_q;
            st_d   = st_clr;
            if (ev_hit && (ev_state >= st_clr)) begin
               st_d = ev_state;
            end
         end

         always_ff @(posedge clk_50M) begin
            if (reset) begin
               st_q <= ST_IDLE;
            end else begin
               st_q <= st_d;
            end
         end

         assign fault_d[gi] = (st_d == ST_FAULT);
         assign block_d[gi] = (st_d == ST_BLOCK);
         assign drop_d[gi]  = (st_d == ST_DROP);
      end
   endgenerate

   logic [IDX_W:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         cnt_d = cnt_d + {{IDX_W{1'b0}}, (fault_d[k] | block_d[k] | drop_d[k])};
      end
   end

   logic r_mask;

`ifdef FAULT_LED_BLINK_EN
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CNT_W-1:0] blink_cnt_q;
   logic [CNT_W-1:0] blink_cnt_d;
   logic             phase_q;
   logic             phase_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
      if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   // Use the next phase so the masked r register lines up with phase_q.
   assign r_mask = phase_d;
`else
   assign r_mask = 1'b1;
`endif

   logic [NUM_UNITS-1:0] r_q;
   logic [NUM_UNITS-1:0] g_q;
   logic [NUM_UNITS-1:0] z_q;
   logic [IDX_W:0]       active_cnt_q;

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         r_q          <= '0;
         g_q          <= '0;
         z_q          <= '0;
         active_cnt_q <= '0;
      end else begin
         r_q          <= fault_d & {NUM_UNITS{r_mask}};
         g_q          <= drop_d;
         z_q          <= block_d;
         active_cnt_q <= cnt_d;
      end
   end

   assign r          = r_q;
   assign g          = g_q;
   assign z          = z_q;
   assign active_cnt = active_cnt_q;

endmodule

// File: tb/tb_fault_led_ctrl.sv
// Directed self-checking bench for fault_led_ctrl (NUM_UNITS=3, IDX_W=2, BLINK_DIV=4).
module tb_fault_led_ctrl;

   logic       clk_50M = 1'b0;
   logic       reset = 1'b1;
   logic       ev_valid = 1'b0;
   logic [1:0] ev_unit = 2'd0;
   logic       i_fault = 1'b0;
   logic       p_block = 1'b0;
   logic       b_drop = 1'b0;
   logic       clr_valid = 1'b0;
   logic [1:0] clr_unit = 2'd0;
   logic       clr_all = 1'b0;
   logic [2:0] r;
   logic [2:0] g;
   logic [2:0] z;
   logic [2:0] active_cnt;

   int checks = 0;
   int passed = 0;

   fault_led_ctrl #(
      .NUM_UNITS(3),
      .IDX_W(2),
      .BLINK_DIV(4)
   ) dut (
      .clk_50M(clk_50M),
      .reset(reset),
      .ev_valid(ev_valid),
      .ev_unit(ev_unit),
      .i_fault(i_fault),
      .p_block(p_block),
      .b_drop(b_drop),
      .clr_valid(clr_valid),
      .clr_unit(clr_unit),
      .clr_all(clr_all),
      .r(r),
      .g(g),
      .z(z),
      .active_cnt(active_cnt)
   );

   always #5 clk_50M = ~clk_50M;

   // Observed outputs packed as {r, g, z, active_cnt}
   logic [11:0] obs;
   assign obs = {r, g, z, active_cnt};

   task automatic tick();
      @(posedge clk_50M);
      @(negedge clk_50M);
   endtask

   task automatic idle_inputs();
      ev_valid  = 1'b0;
      ev_unit   = 2'd0;
      i_fault   = 1'b0;
      p_block   = 1'b0;
      b_drop    = 1'b0;
      clr_valid = 1'b0;
      clr_unit  = 2'd0;
      clr_all   = 1'b0;
   endtask

   task automatic set_event(input logic [1:0] unit, input logic f, input logic p, input logic b);
      ev_valid = 1'b1;
      ev_unit  = unit;
      i_fault  = f;
      p_block  = p;
      b_drop   = b;
   endtask

   task automatic event_cycle(input logic [1:0] unit, input logic f, input logic p, input logic b);
      set_event(unit, f, p, b);
      tick();
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      checks++;
      if (obs !== {3'b000, 3'b000, 3'b000, 3'd0})
         $display("FAIL reset_held: got r=%b g=%b z=%b cnt=%0d, want all 0", r, g, z, active_cnt);
      else passed++;
      reset = 1'b0;
      repeat (5) tick();
      checks++;
      if (obs !== {3'b000, 3'b000, 3'b000, 3'd0})
         $display("FAIL reset_idle: got r=%b g=%b z=%b cnt=%0d, want all 0", r, g, z, active_cnt);
      else passed++;
      $display("test_reset: r=%b g=%b z=%b cnt=%0d", r, g, z, active_cnt);
   endtask

   task automatic test_drop_to_fault();
      event_cycle(2'd1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== {3'b000, 3'b010, 3'b000, 3'd1})
         $display("FAIL drop_u1: got r=%b g=%b z=%b cnt=%0d, want r=000 g=010 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      event_cycle(2'd1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b010, 3'b000, 3'b000, 3'd1})
         $display("FAIL fault_u1: got r=%b g=%b z=%b cnt=%0d, want r=010 g=000 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      event_cycle(2'd1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== {3'b010, 3'b000, 3'b000, 3'd1})
         $display("FAIL drop_no_downgrade: got r=%b g=%b z=%b cnt=%0d, want r=010 g=000 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      // Flags without ev_valid must be ignored
      ev_unit = 2'd0;
      i_fault = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (obs !== {3'b010, 3'b000, 3'b000, 3'd1})
         $display("FAIL no_strobe: got r=%b g=%b z=%b cnt=%0d, want r=010 g=000 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      event_cycle(2'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b010, 3'b000, 3'b000, 3'd1})
         $display("FAIL no_flags: got r=%b g=%b z=%b cnt=%0d, want r=010 g=000 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      $display("test_drop_to_fault: r=%b g=%b z=%b cnt=%0d", r, g, z, active_cnt);
   endtask

   task automatic test_no_downgrade();
      clr_all = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (obs !== {3'b000, 3'b000, 3'b000, 3'd0})
         $display("FAIL clr_all: got r=%b g=%b z=%b cnt=%0d, want all 0", r, g, z, active_cnt);
      else passed++;
      event_cycle(2'd2, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b100, 3'b000, 3'b000, 3'd1})
         $display("FAIL fault_u2: got r=%b g=%b z=%b cnt=%0d, want r=100 g=000 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      event_cycle(2'd2, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== {3'b100, 3'b000, 3'b000, 3'd1})
         $display("FAIL block_no_downgrade: got r=%b g=%b z=%b cnt=%0d, want r=100 g=000 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      clr_valid = 1'b1;
      clr_unit  = 2'd3;
      tick();
      idle_inputs();
      checks++;
      if (obs !== {3'b100, 3'b000, 3'b000, 3'd1})
         $display("FAIL clr_out_of_range: got r=%b g=%b z=%b cnt=%0d, want r=100 g=000 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      clr_valid = 1'b1;
      clr_unit  = 2'd2;
      tick();
      idle_inputs();
      checks++;
      if (obs !== {3'b000, 3'b000, 3'b000, 3'd0})
         $display("FAIL clr_u2: got r=%b g=%b z=%b cnt=%0d, want all 0", r, g, z, active_cnt);
      else passed++;
      $display("test_no_downgrade: r=%b g=%b z=%b cnt=%0d", r, g, z, active_cnt);
   endtask

   task automatic test_clear_with_event();
      event_cycle(2'd1, 1'b0, 1'b0, 1'b1);
      event_cycle(2'd2, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b100, 3'b010, 3'b000, 3'd2})
         $display("FAIL setup_u1u2: got r=%b g=%b z=%b cnt=%0d, want r=100 g=010 z=000 cnt=2", r, g, z, active_cnt);
      else passed++;
      clr_all = 1'b1;
      event_cycle(2'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== {3'b000, 3'b000, 3'b001, 3'd1})
         $display("FAIL clr_all_with_event: got r=%b g=%b z=%b cnt=%0d, want r=000 g=000 z=001 cnt=1", r, g, z, active_cnt);
      else passed++;
      event_cycle(2'd3, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b000, 3'b000, 3'b001, 3'd1})
         $display("FAIL ev_out_of_range: got r=%b g=%b z=%b cnt=%0d, want r=000 g=000 z=001 cnt=1", r, g, z, active_cnt);
      else passed++;
      // Clear then event on the same unit: a lower event still lands after the clear
      clr_valid = 1'b1;
      clr_unit  = 2'd0;
      event_cycle(2'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== {3'b000, 3'b001, 3'b000, 3'd1})
         $display("FAIL clr_unit_with_event: got r=%b g=%b z=%b cnt=%0d, want r=000 g=001 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      event_cycle(2'd1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== {3'b000, 3'b001, 3'b010, 3'd2})
         $display("FAIL block_u1: got r=%b g=%b z=%b cnt=%0d, want r=000 g=001 z=010 cnt=2", r, g, z, active_cnt);
      else passed++;
      $display("test_clear_with_event: r=%b g=%b z=%b cnt=%0d", r, g, z, active_cnt);
   endtask

   task automatic test_priority_and_reset();
      clr_all = 1'b1;
      tick();
      idle_inputs();
      event_cycle(2'd0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs !== {3'b001, 3'b000, 3'b000, 3'd1})
         $display("FAIL all_flags_u0: got r=%b g=%b z=%b cnt=%0d, want r=001 g=000 z=000 cnt=1", r, g, z, active_cnt);
      else passed++;
      reset = 1'b1;
      event_cycle(2'd1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== {3'b000, 3'b000, 3'b000, 3'd0})
         $display("FAIL reset_over_event: got r=%b g=%b z=%b cnt=%0d, want all 0", r, g, z, active_cnt);
      else passed++;
      reset = 1'b0;
      tick();
      checks++;
      if (obs !== {3'b000, 3'b000, 3'b000, 3'd0})
         $display("FAIL after_reset: got r=%b g=%b z=%b cnt=%0d, want all 0", r, g, z, active_cnt);
      else passed++;
      $display("test_priority_and_reset: r=%b g=%b z=%b cnt=%0d", r, g, z, active_cnt);
   endtask

`ifdef FAULT_LED_BLINK_EN
   task automatic test_blink();
      logic prev;
      logic found;
      found = 1'b0;
      event_cycle(2'd0, 1'b1, 1'b0, 1'b0);
      event_cycle(2'd1, 1'b0, 1'b0, 1'b1);
      prev = r[0];
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         if (!prev && r[0]) found = 1'b1;
         prev = r[0];
      end
      checks++;
      if (!found)
         $display("FAIL blink_rise: got no rising edge on r[0] within 12 cycles, want one");
      else passed++;
      for (int i = 1; i < 8; i++) begin
         tick();
         checks++;
         if ({r[0], g[1]} !== {(i < 4), 1'b1})
            $display("FAIL blink_cycle%0d: got r0=%b g1=%b, want r0=%b g1=1", i, r[0], g[1], (i < 4));
         else passed++;
      end
      $display("test_blink: r=%b g=%b z=%b cnt=%0d", r, g, z, active_cnt);
   endtask
`endif

   initial begin
      test_reset();
`ifdef FAULT_LED_BLINK_EN
      test_blink();
`else
      test_drop_to_fault();
      test_no_downgrade();
      test_clear_with_event();
      test_priority_and_reset();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
